// File: rtl/ezrisc_mem_pkg.sv
// Shared types and constants for the ezrisc memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ezrisc_mem_pkg;

  localparam int MEM_DATA_W     = 32;
  // Wide enough for the largest wait-state count (15).
  localparam int MEM_WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_ram_array.sv
// Single-port synchronous RAM, DATA_W x 2**ADDR_W, registered read data.
// Latency: write commits at the edge where we_i is high; rdata_o updates at the edge where re_i is high.
// Backpressure: none; rdata_o holds its value while re_i is low.
// Ports: clk_i clock; we_i/re_i write/read enables (mutually exclusive);
//        addr_i word address; wdata_i write word; rdata_o registered read word.
module mem_ram_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  // Storage is deliberately not reset.
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory target with programmable wait states and a 4-phase read/write handshake.
// Latency: mem_done is high WAIT_STATES+1 cycles after the accepting edge (both-strobe errors complete after 1).
// Backpressure: requests seen while busy are ignored; the strobes must drop before the next request is accepted.
// Ports: clk, reset_n (sync, active-low); mar_addr/mdr_data request address/data;
//        read/write level strobes; m_data_in read data; mem_done completion pulse;
//        mem_busy high while not idle; addr_err pulse with mem_done on a rejected access.
module mem_responder
  import ezrisc_mem_pkg::*;
#(
  parameter int DATA_W      = MEM_DATA_W,
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       mar_addr,
  input  logic [DATA_W-1:0] mdr_data,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] m_data_in,
  output logic              mem_done,
  output logic              mem_busy,
  output logic              addr_err
);

  localparam logic [MEM_WAIT_CNT_W-1:0] WAIT_LOAD = MEM_WAIT_CNT_W'(WAIT_STATES);

  mem_state_t                state_q, state_d;
  logic [MEM_WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [DATA_W-1:0]         wdata_q, wdata_d;
  logic                      is_wr_q, is_wr_d;
  logic                      err_q, err_d;
  // When set, m_data_in reads as zero (after reset or a rejected access)
  // instead of the RAM output register.
  logic                      rd_zero_q, rd_zero_d;

  logic                      enter_done;
  logic                      ram_we;
  logic                      ram_re;
  logic [DATA_W-1:0]         ram_rdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_wr_d    = is_wr_q;
    err_d      = err_q;
    rd_zero_d  = rd_zero_q;
    enter_done = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;

    case (state_q)
      IDLE: begin
        if (read | write) begin
          addr_d  = mar_addr[ADDR_W-1:0];
          wdata_d = mdr_data;
          is_wr_d = write & ~read;
          err_d   = (read & write) | (|mar_addr[31:ADDR_W]);
          cnt_d   = WAIT_LOAD;
          if (!(read & write) && (WAIT_LOAD != '0)) begin
            state_d = WAIT;
          end else begin
            state_d = DONE;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (!read && !write) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The _d copies hold live inputs on a zero-wait accept and the latched
    // request otherwise, so the commit below works for both paths.
    enter_done = (state_d == DONE) && (state_q != DONE) && reset_n;
    ram_we     = enter_done & is_wr_d & ~err_d;
    ram_re     = enter_done & ~is_wr_d & ~err_d;
    if (enter_done && err_d) begin
      rd_zero_d = 1'b1;
    end else if (ram_re) begin
      rd_zero_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      is_wr_q   <= 1'b0;
      err_q     <= 1'b0;
      rd_zero_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      is_wr_q   <= is_wr_d;
      err_q     <= err_d;
      rd_zero_q <= rd_zero_d;
    end
  end

  mem_ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (addr_d),
    .wdata_i (wdata_d),
    .rdata_o (ram_rdata)
  );

  assign m_data_in = rd_zero_q ? '0 : ram_rdata;
  assign mem_done  = (state_q == DONE);
  assign mem_busy  = (state_q != IDLE);
  assign addr_err  = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: three instances (WAIT_STATES 1, 0, 3) against a behavioural model.
// Latency: model expects mem_done WAIT_STATES+1 cycles after acceptance (1 cycle for both-strobe errors).
// Backpressure: strobes are held a random number of cycles past mem_done and must not re-execute.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd_s   [3];
  logic        wr_s   [3];
  logic [31:0] addr_s [3];
  logic [31:0] data_s [3];
  logic [31:0] dout_s [3];
  logic        done_s [3];
  logic        busy_s [3];
  logic        err_s  [3];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: small window of storage per instance plus expected m_data_in.
  logic [31:0] ref_mem    [3][16];
  bit          ref_vld    [3][16];
  logic [31:0] ref_dout   [3];
  bit          ref_dknown [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(
      .DATA_W      (32),
      .ADDR_W      (9),
      .WAIT_STATES ((g == 0) ? 1 : (g == 1) ? 0 : 3)
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .mar_addr  (addr_s[g]),
      .mdr_data  (data_s[g]),
      .read      (rd_s[g]),
      .write     (wr_s[g]),
      .m_data_in (dout_s[g]),
      .mem_done  (done_s[g]),
      .mem_busy  (busy_s[g]),
      .addr_err  (err_s[g])
    );
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_checks(input int k, input string tag);
    check($sformatf("%s_busy%0d", tag, k), 32'(busy_s[k]), 32'd0);
    check($sformatf("%s_done%0d", tag, k), 32'(done_s[k]), 32'd0);
    check($sformatf("%s_err%0d", tag, k), 32'(err_s[k]), 32'd0);
    if (ref_dknown[k]) check($sformatf("%s_dout%0d", tag, k), dout_s[k], ref_dout[k]);
  endtask

  // One full handshake on instance k; strobes held `hold` cycles beyond the done cycle.
  task automatic do_access(input int k, input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdat, input int hold);
    bit          bad;
    int          lat;
    bit          in_win;
    logic [31:0] a;
    a      = addr;
    bad    = (rd && wr) || (a[31:9] != 0);
    lat    = (rd && wr) ? 0 : ws_of(k);
    in_win = (a < 16);

    @(posedge clk); #1;
    rd_s[k] = rd; wr_s[k] = wr; addr_s[k] = addr; data_s[k] = wdat;
    @(posedge clk); #1;
    // Request is latched; these changes must have no effect.
    addr_s[k] = $urandom; data_s[k] = $urandom;

    if (bad) begin
      ref_dout[k] = '0; ref_dknown[k] = 1'b1;
    end else if (wr) begin
      if (in_win) begin ref_mem[k][a[3:0]] = wdat; ref_vld[k][a[3:0]] = 1'b1; end
    end else begin
      ref_dknown[k] = in_win && ref_vld[k][a[3:0]];
      if (ref_dknown[k]) ref_dout[k] = ref_mem[k][a[3:0]];
    end

    for (int i = 0; i <= lat; i++) begin
      @(negedge clk);
      check($sformatf("done%0d_c%0d", k, i), 32'(done_s[k]), 32'(i == lat));
      check($sformatf("busy%0d_c%0d", k, i), 32'(busy_s[k]), 32'd1);
      check($sformatf("aerr%0d_c%0d", k, i), 32'(err_s[k]), 32'(i == lat && bad));
      if (i == lat && ref_dknown[k]) check($sformatf("rdat%0d", k), dout_s[k], ref_dout[k]);
      if (i < lat) @(posedge clk);
    end
    for (int j = 0; j < hold; j++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("held_done%0d", k), 32'(done_s[k]), 32'd0);
      check($sformatf("held_busy%0d", k), 32'(busy_s[k]), 32'd1);
    end
    @(posedge clk); #1;
    rd_s[k] = 1'b0; wr_s[k] = 1'b0;
    @(posedge clk); @(negedge clk);
    idle_checks(k, "post");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] a;
    int          op;
    int          k;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_s[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = '0; data_s[i] = '0;
      ref_dout[i] = '0; ref_dknown[i] = 1'b1;
      for (int j = 0; j < 16; j++) ref_vld[i][j] = 1'b0;
    end

    // Reset held for two edges.
    @(posedge clk); @(posedge clk); @(negedge clk);
    for (int i = 0; i < 3; i++) idle_checks(i, "rst");
    reset_n = 1'b1;

    // WAIT_STATES=1: write then read address 2.
    do_access(0, 1'b0, 1'b1, 32'd2, 32'h0000_0022, 0);
    do_access(0, 1'b1, 1'b0, 32'd2, 32'h0, 0);
    check("wr_rd_a2", dout_s[0], 32'h0000_0022);

    // WAIT_STATES=0: back-to-back, read held three extra cycles.
    do_access(1, 1'b0, 1'b1, 32'd5, 32'h0000_00FF, 0);
    do_access(1, 1'b1, 1'b0, 32'd5, 32'h0, 3);
    check("ws0_rd_a5", dout_s[1], 32'h0000_00FF);

    // Out-of-range address, then both strobes; address 2 keeps its value.
    do_access(0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 0);
    check("bad_addr_dout", dout_s[0], 32'h0);
    do_access(0, 1'b1, 1'b1, 32'd2, 32'h0000_0055, 1);
    do_access(0, 1'b1, 1'b0, 32'd2, 32'h0, 0);
    check("both_keep_a2", dout_s[0], 32'h0000_0022);

    // WAIT_STATES=3: reset during the wait drops the write to address 7.
    do_access(2, 1'b0, 1'b1, 32'd7, 32'h0000_1234, 0);
    @(posedge clk); #1;
    wr_s[2] = 1'b1; addr_s[2] = 32'd7; data_s[2] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    addr_s[2] = $urandom; data_s[2] = $urandom;
    @(negedge clk);
    check("midrst_busy", 32'(busy_s[2]), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b0; wr_s[2] = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin ref_dout[i] = '0; ref_dknown[i] = 1'b1; end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("midrst_done_c%0d", c), 32'(done_s[2]), 32'd0);
      check($sformatf("midrst_idle_c%0d", c), 32'(busy_s[2]), 32'd0);
    end
    do_access(2, 1'b1, 1'b0, 32'd7, 32'h0, 0);
    check("midrst_a7", dout_s[2], 32'h0000_1234);

    // Randomized traffic.
    for (int it = 0; it < 150; it++) begin
      k  = $urandom_range(0, 2);
      op = $urandom_range(0, 9);
      a  = 32'($urandom_range(0, 15));
      if (op == 9) a = a | (32'h1 << $urandom_range(9, 31));
      case (op)
        0, 1, 2, 3: do_access(k, 1'b0, 1'b1, a, $urandom, $urandom_range(0, 2));
        8:          do_access(k, 1'b1, 1'b1, a, $urandom, $urandom_range(0, 2));
        9:          do_access(k, op[0] ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0, a, $urandom, 0);
        default:    do_access(k, 1'b1, 1'b0, a, $urandom, $urandom_range(0, 2));
      endcase
      for (int g = $urandom_range(0, 2); g > 0; g--) @(posedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
